// File: rtl/spi_master_nch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_nch : SPI master, programmable mode/divider, CS_NUM selects,  |
// |                  burst hold. Optional SPI_LOOPBACK_EN adds loopback port. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_master_nch #(
   parameter int DATA_W = 8,
   parameter int CS_NUM = 2,
   parameter int DIV_W  = 8,
   localparam int SEL_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [SEL_W-1:0]  cs_sel,
   input  logic              cs_hold,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              sclk,
   output logic [CS_NUM-1:0] cs_n,
   output logic              mosi,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done
);

   localparam int EW = $clog2(2 * DATA_W + 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, TRAIL, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
   logic              hold_q, hold_d, gap_q, gap_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic              mosi_q, mosi_d, sclk_q, sclk_d;
   logic              done_pend_q, done_pend_d, done_q, done_d;

   logic              accept, last, smp_in, tx_bit, cs_act;
   logic [DIV_W-1:0]  div_eff;

   assign div_eff = (clk_div == '0) ? DIV_W'(1) : clk_div;
   assign last    = (cnt_q == div_q - DIV_W'(1));
   assign accept  = start && (state_q == IDLE || state_q == HOLD);
   assign tx_bit  = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
`ifdef SPI_LOOPBACK_EN
   assign smp_in  = loopback ? mosi_q : miso;
`else
   assign smp_in  = miso;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      edge_d      = edge_q;
      div_d       = div_q;
      sel_d       = sel_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      lsb_d       = lsb_q;
      hold_d      = hold_q;
      gap_d       = gap_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      mosi_d      = mosi_q;
      sclk_d      = sclk_q;
      done_pend_d = 1'b0;
      done_d      = done_pend_q;
      rx_data_d   = done_pend_q ? rx_sh_q : rx_data_q;

      if (state_q == SETUP || state_q == XFER || state_q == TRAIL)
         cnt_d = last ? '0 : cnt_q + DIV_W'(1);

      if (accept) begin
         div_d   = div_eff;
         sel_d   = cs_sel;
         cpol_d  = cpol;
         cpha_d  = cpha;
         lsb_d   = lsb_first;
         hold_d  = cs_hold;
         gap_d   = 1'b0;
         edge_d  = '0;
         sclk_d  = cpol;
         tx_sh_d = tx_data;
         // cpha=0 needs the first bit on the wire before the first edge
         if (!cpha) begin
            mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
            tx_sh_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
         end
      end

      case (state_q)
         IDLE: begin
            sclk_d = cpol;
            if (accept) state_d = SETUP;
         end
         SETUP: begin
            if (last) begin
               if (gap_q) gap_d   = 1'b0;
               else       state_d = XFER;
            end
         end
         XFER: begin
            if (last) begin
               sclk_d = ~sclk_q;
               edge_d = edge_q + EW'(1);
               // edge_q even means the upcoming edge is odd-numbered
               if (edge_q[0] == cpha_q) begin
                  rx_sh_d = lsb_q ? {smp_in, rx_sh_q[DATA_W-1:1]}
                                  : {rx_sh_q[DATA_W-2:0], smp_in};
               end else begin
                  mosi_d  = tx_bit;
                  tx_sh_d = lsb_q ? {1'b0, tx_sh_q[DATA_W-1:1]}
                                  : {tx_sh_q[DATA_W-2:0], 1'b0};
               end
               if (edge_q == EW'(2 * DATA_W - 1)) state_d = TRAIL;
            end
         end
         TRAIL: begin
            sclk_d = cpol_q;
            if (last) begin
               done_pend_d = 1'b1;
               state_d     = hold_q ? HOLD : IDLE;
            end
         end
         HOLD: begin
            if (accept) begin
               if (cs_sel == sel_q) begin
                  state_d = XFER;
               end else begin
                  state_d = SETUP;
                  gap_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         edge_q      <= '0;
         div_q       <= '0;
         sel_q       <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         lsb_q       <= 1'b0;
         hold_q      <= 1'b0;
         gap_q       <= 1'b0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         mosi_q      <= 1'b0;
         sclk_q      <= 1'b0;
         done_pend_q <= 1'b0;
         done_q      <= 1'b0;
         rx_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         edge_q      <= edge_d;
         div_q       <= div_d;
         sel_q       <= sel_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         lsb_q       <= lsb_d;
         hold_q      <= hold_d;
         gap_q       <= gap_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         mosi_q      <= mosi_d;
         sclk_q      <= sclk_d;
         done_pend_q <= done_pend_d;
         done_q      <= done_d;
         rx_data_q   <= rx_data_d;
      end
   end

   // Select stays low through HOLD so a burst keeps the slave framed
   assign cs_act = (state_q == SETUP && !gap_q) || state_q == XFER ||
                   state_q == TRAIL || state_q == HOLD;

   always_comb begin
      cs_n = '1;
      for (int i = 0; i < CS_NUM; i++)
         if (cs_act && sel_q == SEL_W'(i)) cs_n[i] = 1'b0;
   end

   assign sclk    = sclk_q;
   assign mosi    = (state_q == IDLE) ? 1'b0 : mosi_q;
   assign rx_data = rx_data_q;
   assign done    = done_q;
   assign busy    = (state_q == SETUP || state_q == XFER || state_q == TRAIL);

endmodule
`default_nettype wire

// File: tb/tb_spi_master_nch.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_spi_master_nch : vector table + slave model + scoreboard for the      |
// |                     SPI master. Revision 1.0                             |
// +--------------------------------------------------------------------------+
module tb_spi_master_nch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] clk_div = '0;
   logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
   logic [0:0] cs_sel = '0;
   logic       cs_hold = 1'b0, start = 1'b0;
   logic [7:0] tx_data = '0;
   logic       miso = 1'b0;
   logic       sclk, mosi, busy, done;
   logic [1:0] cs_n;
   logic [7:0] rx_data;
`ifdef SPI_LOOPBACK_EN
   logic       loopback = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_master_nch #(.DATA_W(8), .CS_NUM(2), .DIV_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
      .lsb_first(lsb_first), .cs_sel(cs_sel), .cs_hold(cs_hold), .start(start),
      .tx_data(tx_data), .miso(miso),
`ifdef SPI_LOOPBACK_EN
      .loopback(loopback),
`endif
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .rx_data(rx_data), .busy(busy),
      .done(done)
   );

   typedef struct {
      logic       cpol, cpha, lsb;
      logic [7:0] div;
      logic       sel, hold;
      logic [7:0] tx, slv;
   } vec_t;

   typedef struct {
      logic [7:0] exp_rx, exp_tx;
      int         accept, lat, gap;
      logic [1:0] cs_done;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vt[10];
   int   n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0, gap_cyc = 0, cs1_high = 0;
   bit   watch_cs1 = 0, in_hold = 0, hold_sel = 0, slv_inv = 0;

   // Slave model state
   logic [7:0] m_word = '0, s_word = '0, s_cap = '0;
   logic       m_lsb = 0, m_cpha = 0, s_lsb = 0, s_cpha = 0;
   logic [1:0] m_cs = 2'b11, s_cs = 2'b11;
   int         s_k = 0, s_idx = 0;
   bit         s_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic bitsel(input logic [7:0] w, input logic lsb, input int i);
      return lsb ? w[i] : w[7-i];
   endfunction

   always @(posedge busy) begin
      s_k = 0; s_cap = '0; s_bad = 0;
      s_word = m_word; s_lsb = m_lsb; s_cpha = m_cpha; s_cs = m_cs;
      if (!s_cpha) miso = bitsel(s_word, s_lsb, 0) ^ slv_inv;
   end

   always @(sclk) begin
      if (busy) begin
         s_k++;
         if (cs_n != s_cs) s_bad = 1;
         if (s_k % 2 == 1) begin
            s_idx = (s_k - 1) / 2;
            if (!s_cpha) begin
               if (s_lsb) s_cap[s_idx] = mosi; else s_cap[7-s_idx] = mosi;
            end else begin
               miso = bitsel(s_word, s_lsb, s_idx) ^ slv_inv;
            end
         end else begin
            s_idx = s_k / 2;
            if (!s_cpha) begin
               if (s_k < 16) miso = bitsel(s_word, s_lsb, s_idx) ^ slv_inv;
            end else begin
               if (s_lsb) s_cap[s_idx-1] = mosi; else s_cap[8-s_idx] = mosi;
            end
         end
      end
   end

   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst_n) begin
         gap_cyc = 0;
      end else begin
         if (busy && cs_n == 2'b11) gap_cyc++;
         if (watch_cs1 && cs_n[1]) cs1_high++;
         if (done) begin
            done_cnt++;
            check("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               sb_t e;
               e = sb_q.pop_front();
               check("rx_data", rx_data, e.exp_rx);
               check("mosi_word", s_cap, e.exp_tx);
               check("latency", cyc - e.accept, e.lat);
               check("sclk_edges", s_k, 16);
               check("cs_during_xfer", s_bad, 0);
               check("cs_gap_cycles", gap_cyc, e.gap);
               check("cs_n_at_done", cs_n, e.cs_done);
               check("busy_at_done", busy, 0);
            end
            gap_cyc = 0;
         end
      end
   end

   task automatic launch(input vec_t v);
      int  d;
      sb_t e;
      d = (v.div == 0) ? 1 : int'(v.div);
      e.exp_rx = v.slv ^ {8{slv_inv}};
      e.exp_tx = v.tx;
      e.lat = 18 * d + 1;
      e.gap = 0;
      if (in_hold) begin
         if (v.sel == hold_sel) e.lat -= d;
         else begin e.lat += d; e.gap = d; end
      end
      m_cs = v.sel ? 2'b01 : 2'b10;
      e.cs_done = v.hold ? m_cs : 2'b11;
      m_word = v.slv; m_lsb = v.lsb; m_cpha = v.cpha;
      @(posedge clk); #1;
      cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; clk_div = v.div;
      cs_sel = v.sel; cs_hold = v.hold; tx_data = v.tx;
      @(posedge clk); #1;
      start = 1'b1;
      e.accept = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      // Inputs are latched at accept; disturb them to prove it
      cpha = ~v.cpha; lsb_first = ~v.lsb; clk_div = 8'd7;
      cs_sel = ~v.sel; cs_hold = ~v.hold; tx_data = ~v.tx;
      in_hold = v.hold; hold_sel = v.sel;
   endtask

   task automatic wait_done(input int n0);
      int i;
      i = 0;
      while (done_cnt == n0 && i < 3000) begin
         @(posedge clk); #2;
         i++;
      end
      check("done_seen", done_cnt != n0, 1);
   endtask

   task automatic xfer(input vec_t v);
      int n0;
      n0 = done_cnt;
      launch(v);
      wait_done(n0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int   n0, i;
      vec_t v;
      //        cpol  cpha  lsb   div    sel   hold  tx     slv
      vt[0] = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 8'hA5, 8'h3C};
      vt[1] = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 8'h81, 8'hC3};
      vt[2] = '{1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 8'h81, 8'h5E};
      vt[3] = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 8'h81, 8'h27};
      vt[4] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'hFF, 8'h00};
      vt[5] = '{1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 8'h00, 8'hFF};
      vt[6] = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 8'h6B, 8'h94};
      vt[7] = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 8'hD2, 8'h2D};
      vt[8] = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 8'h11, 8'hEE};
      vt[9] = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 8'hC8, 8'h37};

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_sclk", sclk, 0);
      check("rst_cs_n", cs_n, 2'b11);
      check("rst_mosi", mosi, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int k = 0; k < 10; k++) xfer(vt[k]);

      // Burst on select 1: CS must never rise between the two words
      xfer('{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 8'h12, 8'hA7});
      check("hold_cs_n", cs_n, 2'b01);
      check("hold_busy", busy, 0);
      cs1_high = 0;
      watch_cs1 = 1;
      xfer('{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 8'h34, 8'h5C});
      watch_cs1 = 0;
      check("burst_cs1_high_cycles", cs1_high, 0);
      xfer('{1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 8'h9A, 8'h65});

      // Start during XFER must be ignored
      n0 = done_cnt;
      launch('{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 8'hC3, 8'h69});
      i = 0;
      while (s_k < 4 && i < 500) begin @(posedge clk); #1; i++; end
      check("reached_xfer", s_k >= 4, 1);
      start = 1'b1; tx_data = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n0);
      repeat (60) @(posedge clk);
      #2;
      check("single_done", done_cnt - n0, 1);

      // Reset around bit 4 aborts the transfer without a done pulse
      n0 = done_cnt;
      m_word = 8'h55; m_lsb = 0; m_cpha = 0; m_cs = 2'b10;
      cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd2;
      cs_sel = 1'b0; cs_hold = 1'b0; tx_data = 8'hE7;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      i = 0;
      while (s_k < 8 && i < 500) begin @(posedge clk); #1; i++; end
      check("reached_bit4", s_k >= 8, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_cs_n", cs_n, 2'b11);
      check("abort_sclk", sclk, 0);
      check("abort_mosi", mosi, 0);
      check("abort_busy", busy, 0);
      check("abort_rx_data", rx_data, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      in_hold = 0;
      @(posedge clk); #1;
      check("post_rst_sclk_cpol", sclk, 1);
      check("post_rst_busy", busy, 0);
      repeat (60) @(posedge clk);
      #2;
      check("abort_no_done", done_cnt - n0, 0);
      xfer('{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 8'hE7, 8'h18});

`ifdef SPI_LOOPBACK_EN
      loopback = 1'b1;
      slv_inv = 1;
      v = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 8'h5A, 8'hA5};
      xfer(v);
      loopback = 1'b0;
      slv_inv = 0;
`else
      v = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 8'h5A, 8'h0F};
      xfer(v);
`endif

      repeat (5) @(posedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
